conv2d_stream: RTL and testbench
================================

# conv2d_stream

Parametrised streaming 2-D convolution engine, successor to the fixed 5x5-map / 3x3-kernel convolution block. It loads a KxK kernel once, then accepts NxN feature-map frames row-major, one pixel per cycle, using K-1 line buffers. It emits the (N-K+1)x(N-K+1) valid-mode results with a linear output index and valid/ready backpressure. It sits between the pixel source and the pooling/activation stage.

## Interface
- N, 5: map width/height in pixels (N >= K).
- K, 3: kernel width/height (K >= 2).
- DATA_W, 8: unsigned map pixel width.
- COEF_W, 8: unsigned kernel coefficient width.
- OUT_W, 8: output width.
- SHIFT, 0: right shift applied to the accumulator before output narrowing.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- kern_valid  in  1  coefficient offered.
- kern_data  in  COEF_W  coefficient, row-major order k[0][0] .. k[K-1][K-1].
- kern_ready  out  1  high only in S_KLOAD.
- kern_reload  in  1  one-cycle pulse; returns the block to S_KLOAD between frames.
- map_valid  in  1  pixel offered.
- map_data  in  DATA_W  pixel, row-major.
- map_ready  out  1  pixel accepted when map_valid && map_ready.
- out_valid  out  1  result valid.
- out_data  out  OUT_W  convolution result.
- out_index  out  clog2((N-K+1)^2)  row-major output index.
- out_last  out  1  marks the final result of a frame.
- out_ready  in  1  downstream accept.

## Operation
- State S_KLOAD: accept K*K coefficients into the kernel registers. After the last one, go to S_MAP.
- State S_MAP: accept pixels and track row/col counters (0..N-1). Each accepted pixel shifts into its line buffer and into the KxK window.
  - When row >= K-1 and col >= K-1, the window is complete and a result is issued.
  - The window at output (r,c) covers map[r..r+K-1][c..c+K-1], multiplied element-wise by k[i][j].
- After the last pixel of a frame (row=N-1, col=N-1), the counters wrap to 0 and the block stays in S_MAP for the next frame with the same kernel.
- kern_reload is honoured only when the counters are at 0 and the pipeline is empty; otherwise it is ignored.
- Arithmetic:
  - Products are DATA_W+COEF_W bits.
  - The accumulator is ACC_W = DATA_W+COEF_W+clog2(K*K) bits, so there is no internal overflow.
  - The result is acc >> SHIFT, then narrowed to OUT_W bits per Configuration.
- out_index counts 0..(N-K+1)^2-1 and resets to 0 at each frame start. out_last is high with index (N-K+1)^2-1.

## Timing
- Reset values: kern_ready=0 in the reset cycle, then 1; map_ready=0; out_valid=0, out_data=0, out_index=0, out_last=0. State after reset is S_KLOAD; counters, line buffers and kernel registers are cleared.
- Reset mid-frame or mid-kernel-load discards all partial data. Outputs are zero the following cycle.
- Latency: a result appears on out_valid 2 cycles after its completing pixel is accepted (window register stage, then MAC/output stage).
- Backpressure:
  - Hold: out_data, out_index and out_last stay stable while out_valid && !out_ready.
  - Stall: map_ready = (state==S_MAP) && !(out_valid && !out_ready). The whole pipeline stalls together, so no result is dropped or duplicated.
- Throughput: one pixel per cycle with out_ready held high; frames may be back-to-back with no bubble.
- Edge cases:
  - Pixels with row < K-1 or col < K-1 produce no result.
  - map_valid during S_KLOAD is ignored (map_ready=0).
  - kern_valid during S_MAP is ignored.

## Configuration
- CONV_SAT_EN defined: results greater than 2^OUT_W-1 clamp to 2^OUT_W-1.
- CONV_SAT_EN undefined: the low OUT_W bits of the shifted accumulator are output (wrap).

## Structure
- Package conv_pkg holds:
  - the state enum (S_KLOAD, S_MAP);
  - an ACC_W helper function;
  - a narrowing function that implements both the saturate and wrap variants.
- Sub-module conv_line_buffer: a DATA_W-wide, N-deep shift buffer with enable. The top level instantiates K-1 of them.
- The window, MAC tree, counters and handshake live in the top level.

## Test plan
- N=5, K=3; kernel all 1; map all 1 -> 9 results of 9, indices 0..8, out_last only on index 8.
- Kernel centre=1, others 0; map[i]=i (0..24) -> results 6,7,8,11,12,13,16,17,18 in order.
- Map all 255, kernel all 1, SHIFT=0 -> 255 with CONV_SAT_EN; 247 (2295 mod 256) without.
- out_ready low for 5 cycles mid-frame -> map_ready low for those cycles, out_data held, full 9-result sequence intact.
- rst asserted after 12 pixels -> next cycle out_valid=0, kern_ready=1; a fresh kernel plus frame gives the correct results.
- Two back-to-back frames, then kern_reload plus a new kernel (all 2) and a third frame -> results of 9, 9, then 18, with indices restarting at 0 each frame.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and arithmetic helpers for the streaming 2-D convolution engine.
package conv_pkg;

  typedef enum logic {
    S_KLOAD,
    S_MAP
  } state_e;

  // Accumulator width that cannot overflow for a KxK sum of products.
  function automatic int unsigned acc_width(input int unsigned data_w,
                                            input int unsigned coef_w,
                                            input int unsigned k);
    return data_w + coef_w + $clog2(k * k);
  endfunction

  // Narrow v to out_w bits: clamp to the maximum when sat is set, else wrap.
  function automatic logic [63:0] narrow(input logic [63:0] v,
                                         input int unsigned out_w,
                                         input bit          sat);
    logic [63:0] lim;
    logic [63:0] res;
    lim = (out_w >= 64) ? '1 : ((64'd1 << out_w) - 64'd1);
    if (sat && (v > lim)) res = lim;
    else                  res = v & lim;
    return res;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One map row of delay: a DEPTH-entry shift register advanced by en_i.
module conv_line_buffer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] dout_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (en_i) begin
      mem_q[0] <= din_i;
      for (int unsigned i = 1; i < DEPTH; i++) mem_q[i] <= mem_q[i-1];
    end
  end

  assign dout_o = mem_q[DEPTH-1];

endmodule

// File: rtl/conv2d_stream.sv
// Streaming KxK valid-mode convolution over NxN frames with valid/ready output.
// Define CONV_SAT_EN to clamp results to the output range instead of wrapping.
module conv2d_stream
  import conv_pkg::*;
#(
  parameter  int unsigned N      = 5,
  parameter  int unsigned K      = 3,
  parameter  int unsigned DATA_W = 8,
  parameter  int unsigned COEF_W = 8,
  parameter  int unsigned OUT_W  = 8,
  parameter  int unsigned SHIFT  = 0,
  localparam int unsigned M      = N - K + 1,
  localparam int unsigned IDX_W  = (M * M > 1) ? $clog2(M * M) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              kern_valid,
  input  logic [COEF_W-1:0] kern_data,
  output logic              kern_ready,
  input  logic              kern_reload,
  input  logic              map_valid,
  input  logic [DATA_W-1:0] map_data,
  output logic              map_ready,
  output logic              out_valid,
  output logic [OUT_W-1:0]  out_data,
  output logic [IDX_W-1:0]  out_index,
  output logic              out_last,
  input  logic              out_ready
);

  localparam int unsigned PROD_W = DATA_W + COEF_W;
  localparam int unsigned ACC_W  = acc_width(DATA_W, COEF_W, K);
  localparam int unsigned RC_W   = $clog2(N);
  localparam int unsigned KC_W   = $clog2(K);

  localparam logic [RC_W-1:0]  LAST_RC   = RC_W'(N - 1);
  localparam logic [RC_W-1:0]  FIRST_WIN = RC_W'(K - 1);
  localparam logic [KC_W-1:0]  LAST_K    = KC_W'(K - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(M * M - 1);

`ifdef CONV_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  state_e state_q, state_d;

  logic [KC_W-1:0]   kr_q, kc_q;
  logic [COEF_W-1:0] kern_q [K][K];

  logic [RC_W-1:0]   row_q, col_q;
  logic [IDX_W-1:0]  oidx_q;

  logic [K-1:0][DATA_W-1:0] tap;
  logic [DATA_W-1:0] win_q [K][K];
  logic              win_vld_q, win_last_q;
  logic [IDX_W-1:0]  win_idx_q;

  logic              out_valid_q, out_last_q;
  logic [OUT_W-1:0]  out_data_q;
  logic [IDX_W-1:0]  out_index_q;

  logic              adv, kern_acc, map_acc, win_done, reload_ok;
  logic [PROD_W-1:0] prod;
  logic [ACC_W-1:0]  acc, acc_sh;
  logic [OUT_W-1:0]  res;

  // The whole pipeline advances together; only a held output result stalls it.
  assign adv        = !(out_valid_q && !out_ready);
  assign kern_ready = (state_q == S_KLOAD) && !rst;
  assign map_ready  = (state_q == S_MAP) && adv;
  assign kern_acc   = kern_valid && kern_ready;
  assign map_acc    = map_valid && map_ready;
  assign win_done   = map_acc && (row_q >= FIRST_WIN) && (col_q >= FIRST_WIN);
  assign reload_ok  = (state_q == S_MAP) && kern_reload && (row_q == '0) && (col_q == '0)
                      && !win_vld_q && !out_valid_q && !map_acc;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_KLOAD: if (kern_acc && (kr_q == LAST_K) && (kc_q == LAST_K)) state_d = S_MAP;
      S_MAP:   if (reload_ok) state_d = S_KLOAD;
      default: state_d = S_KLOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_KLOAD;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      kr_q <= '0;
      kc_q <= '0;
      for (int unsigned i = 0; i < K; i++)
        for (int unsigned j = 0; j < K; j++) kern_q[i][j] <= '0;
    end else if (kern_acc) begin
      kern_q[kr_q][kc_q] <= kern_data;
      if (kc_q == LAST_K) begin
        kc_q <= '0;
        kr_q <= (kr_q == LAST_K) ? '0 : kr_q + 1'b1;
      end else begin
        kc_q <= kc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q  <= '0;
      col_q  <= '0;
      oidx_q <= '0;
    end else if (map_acc) begin
      if (col_q == LAST_RC) begin
        col_q <= '0;
        row_q <= (row_q == LAST_RC) ? '0 : row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
      if (win_done) oidx_q <= (oidx_q == LAST_IDX) ? '0 : oidx_q + 1'b1;
    end
  end

  // tap[0] is the current row; tap[i] is the same column i rows above.
  assign tap[0] = map_data;
  for (genvar g = 0; g < K - 1; g++) begin : g_lb
    conv_line_buffer #(
      .DATA_W (DATA_W),
      .DEPTH  (N)
    ) u_lb (
      .clk    (clk),
      .rst    (rst),
      .en_i   (map_acc),
      .din_i  (tap[g]),
      .dout_o (tap[g+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < K; i++)
        for (int unsigned j = 0; j < K; j++) win_q[i][j] <= '0;
    end else if (map_acc) begin
      for (int unsigned i = 0; i < K; i++) begin
        for (int unsigned j = 0; j < K - 1; j++) win_q[i][j] <= win_q[i][j+1];
        win_q[i][K-1] <= tap[K-1-i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_vld_q  <= 1'b0;
      win_idx_q  <= '0;
      win_last_q <= 1'b0;
    end else if (adv) begin
      win_vld_q  <= win_done;
      win_idx_q  <= oidx_q;
      win_last_q <= (oidx_q == LAST_IDX);
    end
  end

  always_comb begin
    acc  = '0;
    prod = '0;
    for (int unsigned i = 0; i < K; i++) begin
      for (int unsigned j = 0; j < K; j++) begin
        prod = PROD_W'(win_q[i][j]) * PROD_W'(kern_q[i][j]);
        acc  = acc + ACC_W'(prod);
      end
    end
    acc_sh = acc >> SHIFT;
    res    = OUT_W'(narrow(64'(acc_sh), OUT_W, SAT));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
      out_last_q  <= 1'b0;
    end else if (adv) begin
      out_valid_q <= win_vld_q;
      if (win_vld_q) begin
        out_data_q  <= res;
        out_index_q <= win_idx_q;
        out_last_q  <= win_last_q;
      end else begin
        out_last_q  <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_index = out_index_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_conv2d_stream.sv
// Directed bench for conv2d_stream (N=5, K=3): hand-computed results per frame.
`timescale 1ns/1ps
module tb_conv2d_stream;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       kern_valid = 1'b0;
  logic [7:0] kern_data = '0;
  logic       kern_ready;
  logic       kern_reload = 1'b0;
  logic       map_valid = 1'b0;
  logic [7:0] map_data = '0;
  logic       map_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic [3:0] out_index;
  logic       out_last;
  logic       out_ready = 1'b1;

  int unsigned vec_cnt = 0;
  int unsigned err_cnt = 0;

  logic [7:0] dq [$];
  logic [3:0] iq [$];
  logic       lq [$];

`ifdef CONV_SAT_EN
  localparam int SAT_EXP = 255;
`else
  localparam int SAT_EXP = 247;
`endif

  int e_ones [9];
  int e_sat  [9];
  int e_ctr  [9];
  int e_twos [9];

  conv2d_stream #(
    .N      (5),
    .K      (3),
    .DATA_W (8),
    .COEF_W (8),
    .OUT_W  (8),
    .SHIFT  (0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .kern_valid  (kern_valid),
    .kern_data   (kern_data),
    .kern_ready  (kern_ready),
    .kern_reload (kern_reload),
    .map_valid   (map_valid),
    .map_data    (map_data),
    .map_ready   (map_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_index   (out_index),
    .out_last    (out_last),
    .out_ready   (out_ready)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      dq.push_back(out_data);
      iq.push_back(out_index);
      lq.push_back(out_last);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send_coef(input logic [7:0] d);
    int unsigned n;
    n = 0;
    kern_valid = 1'b1;
    kern_data  = d;
    @(negedge clk);
    while (!kern_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!kern_ready) check("kern_ready_timeout", kern_ready, 1);
    @(posedge clk); #1;
  endtask

  task automatic load_kernel(input logic [7:0] v, input bit centre);
    for (int i = 0; i < 9; i++) send_coef(centre ? ((i == 4) ? 8'd1 : 8'd0) : v);
    kern_valid = 1'b0;
  endtask

  task automatic send_pixel(input logic [7:0] d);
    int unsigned n;
    n = 0;
    map_valid = 1'b1;
    map_data  = d;
    @(negedge clk);
    while (!map_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!map_ready) check("map_ready_timeout", map_ready, 1);
    @(posedge clk); #1;
  endtask

  // ramp=1 sends map[i]=i, otherwise every pixel is v; map_valid is left high.
  task automatic send_frame(input bit ramp, input logic [7:0] v);
    for (int i = 0; i < 25; i++) send_pixel(ramp ? 8'(i) : v);
  endtask

  task automatic check_results(input string tag, input int e [9]);
    int unsigned n;
    n = 0;
    while (dq.size() < 9 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_count"}, 32'(dq.size() >= 9), 1);
    for (int k = 0; k < 9; k++) begin
      if (dq.size() > 0) begin
        check({tag, "_data"},  dq.pop_front(), e[k]);
        check({tag, "_index"}, iq.pop_front(), k);
        check({tag, "_last"},  lq.pop_front(), (k == 8) ? 1 : 0);
      end
    end
  endtask

  task automatic do_reload();
    map_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    kern_reload = 1'b1;
    @(posedge clk); #1;
    kern_reload = 1'b0;
    check("reload_kern_ready", kern_ready, 1);
    check("reload_map_ready", map_ready, 0);
  endtask

  initial begin
    longint t0;
    int unsigned cyc, n, pos;

    for (int k = 0; k < 9; k++) begin
      e_ones[k] = 9;
      e_sat[k]  = SAT_EXP;
      e_twos[k] = 18;
    end
    e_ctr = '{6, 7, 8, 11, 12, 13, 16, 17, 18};

    repeat (2) @(posedge clk);
    #1;
    check("rst_kern_ready", kern_ready, 0);
    check("rst_map_ready", map_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_index", out_index, 0);
    check("rst_out_last", out_last, 0);
    rst = 1'b0;
    #1;
    check("post_rst_kern_ready", kern_ready, 1);
    check("post_rst_map_ready", map_ready, 0);

    // Pixels offered during kernel load must be refused.
    map_valid = 1'b1;
    #1;
    check("kload_map_ready", map_ready, 0);
    map_valid = 1'b0;

    load_kernel(8'd1, 1'b0);
    check("map_state_kern_ready", kern_ready, 0);
    send_frame(1'b0, 8'd1);
    map_valid = 1'b0;
    check_results("ones", e_ones);

    send_frame(1'b0, 8'd255);
    map_valid = 1'b0;
    check_results("sat", e_sat);

    do_reload();
    load_kernel(8'd0, 1'b1);
    fork
      begin
        send_frame(1'b1, 8'd0);
        map_valid = 1'b0;
      end
      begin
        n = 0;
        do begin
          @(posedge clk); #1;
          n++;
        end while (!(out_valid && dq.size() >= 2) && n < 300);
        check("stall_start", out_valid, 1);
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          pos = (dq.size() < 9) ? dq.size() : 8;
          check("stall_map_ready", map_ready, 0);
          check("stall_out_valid", out_valid, 1);
          check("stall_out_data", out_data, e_ctr[pos]);
          check("stall_out_index", out_index, pos);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    check_results("ctr_stall", e_ctr);

    // Reset in the middle of a frame, then a fresh kernel and frame.
    do_reload();
    load_kernel(8'd1, 1'b0);
    for (int i = 0; i < 12; i++) send_pixel(8'(i));
    map_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_kern_ready", kern_ready, 1);
    check("midrst_map_ready", map_ready, 0);
    check("midrst_out_index", out_index, 0);
    dq.delete();
    iq.delete();
    lq.delete();
    load_kernel(8'd0, 1'b1);
    send_frame(1'b1, 8'd0);
    map_valid = 1'b0;
    check_results("rst_ctr", e_ctr);

    // Two frames back to back; coefficients offered meanwhile are ignored.
    do_reload();
    load_kernel(8'd1, 1'b0);
    kern_valid = 1'b1;
    kern_data  = 8'd77;
    t0 = $time;
    send_frame(1'b0, 8'd1);
    send_frame(1'b0, 8'd1);
    cyc = int'(($time - t0) / 10);
    map_valid = 1'b0;
    check("b2b_cycles", cyc, 50);
    check("b2b_kern_ready", kern_ready, 0);
    kern_valid = 1'b0;
    check_results("b2b_f1", e_ones);
    check_results("b2b_f2", e_ones);

    do_reload();
    load_kernel(8'd2, 1'b0);
    send_frame(1'b0, 8'd1);
    map_valid = 1'b0;
    check_results("reload_twos", e_twos);

    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
